// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - word-addressed 32-bit RAM with a multi-cycle request/done handshake
// Define MEM_RANGE_CHECK_EN to flag and suppress accesses at addresses >= DEPTH.
module mem_unit #(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              read,
  input  logic              write,
  output logic [31:0]       mDataOut,
  output logic              busy,
  output logic              done,
  output logic              fault
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int WORDS = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic               op_write;
  logic [31:0]        mem [0:WORDS-1];
  logic               in_range;
  logic               commit;
  logic               mem_we;

`ifdef MEM_RANGE_CHECK_EN
  assign in_range = (32'(addr_q) < DEPTH);
`else
  logic unused_depth;
  assign unused_depth = ^DEPTH;
  assign in_range     = 1'b1;
`endif

  // The access lands on the edge where the wait counter has already drained.
  assign commit = (state == S_ACCESS) && (cnt == '0);
  assign mem_we = commit && op_write && in_range;

  // Array kept out of the reset domain; an aborted access never reaches commit.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_write <= 1'b0;
      mDataOut <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (read || write) begin
            state    <= S_ACCESS;
            addr_q   <= addr;
            wdata_q  <= wdata;
            op_write <= write;
            cnt      <= CNT_W'(WAIT_STATES);
            busy     <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            fault <= !in_range;
            if (!op_write) begin
              mDataOut <= in_range ? mem[addr_q] : 32'h0;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          fault <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          fault <= 1'b0;
        end
      endcase
    end
  end

endmodule
